// File: rtl/ram_ctrl_pkg.sv
// Shared types and default widths for the RAM burst controller.
package ram_ctrl_pkg;

    localparam int unsigned DEFAULT_ADDR_WIDTH = 9;
    localparam int unsigned DEFAULT_DATA_WIDTH = 6;

    typedef enum logic [1:0] {
        IDLE,
        WR,
        RD,
        DONE
    } state_t;

endpackage

// File: rtl/ram_burst_ctrl.sv
// Burst controller bridging a request/stream interface onto a single-port RAM
// with synchronous write and combinational read.
module ram_burst_ctrl
    import ram_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [ADDR_WIDTH-1:0] req_len,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    input  logic                  rd_ready,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_write,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic                  mem_read,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    state_t                state;
    state_t                state_next;
    logic [ADDR_WIDTH-1:0] addr;
    logic [ADDR_WIDTH-1:0] count;
    logic                  xfer;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        req_ready  = 1'b0;
        wr_ready   = 1'b0;
        busy       = 1'b1;
        done       = 1'b0;
        mem_addr   = '0;
        mem_write  = 1'b0;
        mem_wdata  = '0;
        mem_read   = 1'b0;
        xfer       = 1'b0;
        case (state)
            IDLE: begin
                busy      = 1'b0;
                req_ready = 1'b1;
                if (req_valid) begin
                    state_next = req_write ? WR : RD;
                end
            end
            WR: begin
                wr_ready = 1'b1;
                mem_addr = addr;
                if (wr_valid) begin
                    mem_write = 1'b1;
                    mem_wdata = wr_data;
                    xfer      = 1'b1;
                    if (count == '0) begin
                        state_next = DONE;
                    end
                end
            end
            RD: begin
                mem_addr = addr;
                // Only read when the output register can take the word.
                if (!rd_valid || rd_ready) begin
                    mem_read = 1'b1;
                    xfer     = 1'b1;
                    if (count == '0) begin
                        state_next = DONE;
                    end
                end
            end
            DONE: begin
                // Write bursts never hold rd_valid, so they leave after one cycle.
                if (!rd_valid || rd_ready) begin
                    done       = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr     <= '0;
            count    <= '0;
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else begin
            if (state == IDLE && req_valid) begin
                addr  <= req_addr;
                count <= req_len;
            end else if (xfer) begin
                addr  <= addr + ADDR_WIDTH'(1);
                count <= count - ADDR_WIDTH'(1);
            end

            if (state == RD && xfer) begin
                rd_data  <= mem_rdata;
                rd_valid <= 1'b1;
            end else if (rd_valid && rd_ready) begin
                rd_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_ram_burst_ctrl.sv
// Randomized bench for ram_burst_ctrl against a RAM model and an array-based
// reference of expected memory contents and stream order.
module tb_ram_burst_ctrl;
    import ram_ctrl_pkg::*;

    localparam int unsigned AW    = DEFAULT_ADDR_WIDTH;
    localparam int unsigned DW    = DEFAULT_DATA_WIDTH;
    localparam int unsigned DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic          req_write = 1'b0;
    logic [AW-1:0] req_addr = '0;
    logic [AW-1:0] req_len = '0;
    logic [DW-1:0] wr_data = '0;
    logic          wr_valid = 1'b0;
    logic          wr_ready;
    logic [DW-1:0] rd_data;
    logic          rd_valid;
    logic          rd_ready = 1'b0;
    logic          busy;
    logic          done;
    logic [AW-1:0] mem_addr;
    logic          mem_write;
    logic [DW-1:0] mem_wdata;
    logic          mem_read;
    wire  [DW-1:0] mem_rdata;

    logic [DW-1:0] ram     [DEPTH];
    logic [DW-1:0] ref_mem [DEPTH];

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;
    int unsigned done_cnt = 0;
    int unsigned cyc      = 0;

    logic [AW+DW-1:0] wq[$];
    logic [DW-1:0]    rq[$];
    int unsigned      rc[$];

    ram_burst_ctrl #(
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_len   (req_len),
        .wr_data   (wr_data),
        .wr_valid  (wr_valid),
        .wr_ready  (wr_ready),
        .rd_data   (rd_data),
        .rd_valid  (rd_valid),
        .rd_ready  (rd_ready),
        .busy      (busy),
        .done      (done),
        .mem_addr  (mem_addr),
        .mem_write (mem_write),
        .mem_wdata (mem_wdata),
        .mem_read  (mem_read),
        .mem_rdata (mem_rdata)
    );

    // Team RAM model: synchronous write, combinational read, released bus when idle.
    always @(posedge clk) begin
        if (mem_write) ram[mem_addr] <= mem_wdata;
    end
    assign mem_rdata = mem_read ? ram[mem_addr] : 'z;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (mem_write || mem_read) check_eq("rw_exclusive", 32'(mem_write && mem_read), 32'd0);
            if (mem_write) begin
                check_eq("wr_on_valid", 32'(wr_valid), 32'd1);
                wq.push_back({mem_addr, mem_wdata});
            end
            if (rd_valid && !rd_ready) check_eq("rd_hold_noread", 32'(mem_read), 32'd0);
            if (rd_valid && rd_ready) begin
                rq.push_back(rd_data);
                rc.push_back(cyc);
            end
            if (done) done_cnt++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [AW-1:0] wrap_addr(input logic [AW-1:0] a, input int unsigned i);
        return AW'((32'(a) + i) % DEPTH);
    endfunction

    task automatic issue(input logic w, input logic [AW-1:0] a, input logic [AW-1:0] len);
        int unsigned n = 0;
        req_valid = 1'b1;
        req_write = w;
        req_addr  = a;
        req_len   = len;
        while (!req_ready && n < 50) begin
            tick();
            n++;
        end
        if (!req_ready) check_eq("req_timeout", 32'd0, 32'd1);
        tick();
        req_valid = 1'b0;
    endtask

    task automatic push_word(input logic [DW-1:0] d);
        int unsigned n = 0;
        wr_valid = 1'b1;
        wr_data  = d;
        while (!wr_ready && n < 50) begin
            tick();
            n++;
        end
        if (!wr_ready) check_eq("wr_timeout", 32'd0, 32'd1);
        tick();
    endtask

    task automatic run_write(input logic [AW-1:0] a, input logic [AW-1:0] len,
                             input int unsigned gap, input bit rnd, input logic [DW-1:0] base);
        logic [AW+DW-1:0] exp_w[$];
        logic [DW-1:0]    d;
        logic [AW-1:0]    wa;
        int unsigned      d0 = done_cnt;
        int unsigned      n = 0;
        int unsigned      g;
        wq.delete();
        issue(1'b1, a, len);
        check_eq("wr_latency", 32'(wr_ready), 32'd1);
        for (int unsigned i = 0; i <= 32'(len); i++) begin
            g = rnd ? $urandom_range(0, 2) : ((i > 0 && i < 32'(len)) ? gap : 0);
            for (int unsigned k = 0; k < g; k++) begin
                wr_valid = 1'b0;
                wr_data  = DW'($urandom);
                tick();
            end
            d  = rnd ? DW'($urandom) : DW'(32'(base) + i);
            wa = wrap_addr(a, i);
            push_word(d);
            ref_mem[wa] = d;
            exp_w.push_back({wa, d});
        end
        wr_valid = 1'b0;
        while (done_cnt == d0 && n < 50) begin
            tick();
            n++;
        end
        tick();
        tick();
        check_eq("wr_done_once", done_cnt - d0, 32'd1);
        check_eq("wr_idle_after", 32'({busy, req_ready}), 32'b01);
        check_eq("wr_beats", wq.size(), exp_w.size());
        for (int unsigned i = 0; i < exp_w.size() && i < wq.size(); i++) begin
            check_eq("wr_beat", 32'(wq[i]), 32'(exp_w[i]));
            wa = exp_w[i][AW+DW-1:DW];
            check_eq("ram_word", 32'(ram[wa]), 32'(ref_mem[wa]));
        end
    endtask

    task automatic run_read(input logic [AW-1:0] a, input logic [AW-1:0] len, input int unsigned mode);
        logic [3:0]  pat = 4'b1001;
        int unsigned d0 = done_cnt;
        int unsigned k = 0;
        rq.delete();
        rc.delete();
        issue(1'b0, a, len);
        check_eq("rd_latency", 32'(mem_read), 32'd1);
        while (done_cnt == d0 && k < 300) begin
            case (mode)
                0:       rd_ready = 1'b1;
                1:       rd_ready = pat[2'(k % 4)];
                default: rd_ready = 1'($urandom_range(0, 1));
            endcase
            tick();
            k++;
        end
        rd_ready = 1'b0;
        tick();
        tick();
        check_eq("rd_done_once", done_cnt - d0, 32'd1);
        check_eq("rd_words", rq.size(), 32'(len) + 1);
        for (int unsigned i = 0; i < rq.size() && i <= 32'(len); i++) begin
            check_eq("rd_word", 32'(rq[i]), 32'(ref_mem[wrap_addr(a, i)]));
            if (mode == 0) check_eq("rd_consecutive", rc[i] - rc[0], i);
        end
    endtask

    initial begin
        logic [AW-1:0] ra;
        logic [AW-1:0] rl;
        int unsigned   d0;

        #1;
        check_eq("rst_req_ready", 32'(req_ready), 32'd1);
        check_eq("rst_wr_ready", 32'(wr_ready), 32'd0);
        check_eq("rst_rd_valid", 32'(rd_valid), 32'd0);
        check_eq("rst_rd_data", 32'(rd_data), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_done", 32'(done), 32'd0);
        check_eq("rst_mem_write", 32'(mem_write), 32'd0);
        check_eq("rst_mem_read", 32'(mem_read), 32'd0);
        check_eq("rst_mem_addr", 32'(mem_addr), 32'd0);
        check_eq("rst_mem_wdata", 32'(mem_wdata), 32'd0);
        tick();
        tick();
        rst = 1'b0;
        tick();

        run_write(AW'('h010), AW'(3), 0, 1'b0, DW'(1));
        for (int unsigned i = 0; i < 4; i++) check_eq("basic_ram", 32'(ram[16 + i]), i + 1);
        run_read(AW'('h010), AW'(3), 0);
        run_read(AW'('h010), AW'(3), 1);

        run_write(AW'('h1FE), AW'(3), 0, 1'b1, '0);
        check_eq("wrap_addr0", 32'(wq[0][AW+DW-1:DW]), 32'h1FE);
        check_eq("wrap_addr2", 32'(wq[2][AW+DW-1:DW]), 32'h000);
        check_eq("wrap_addr3", 32'(wq[3][AW+DW-1:DW]), 32'h001);
        run_read(AW'('h1FE), AW'(3), 2);

        run_write(AW'('h040), AW'(5), 2, 1'b0, DW'('h10));
        run_read(AW'('h040), AW'(5), 0);

        for (int unsigned r = 0; r < 6; r++) begin
            ra = AW'($urandom);
            rl = AW'($urandom_range(0, 7));
            run_write(ra, rl, 0, 1'b1, '0);
            run_read(ra, rl, 2);
        end

        // Abort a write burst after two of four words.
        d0 = done_cnt;
        wq.delete();
        issue(1'b1, AW'('h010), AW'(3));
        for (int unsigned i = 0; i < 2; i++) begin
            push_word(DW'('h2A + i));
            ref_mem[AW'('h010 + i)] = DW'('h2A + i);
        end
        wr_valid = 1'b1;
        wr_data  = DW'('h2C);
        rst = 1'b1;
        #1;
        check_eq("abort_req_ready", 32'(req_ready), 32'd1);
        check_eq("abort_busy", 32'(busy), 32'd0);
        check_eq("abort_wr_ready", 32'(wr_ready), 32'd0);
        check_eq("abort_mem_write", 32'(mem_write), 32'd0);
        tick();
        tick();
        wr_valid = 1'b0;
        rst = 1'b0;
        tick();
        tick();
        check_eq("abort_no_done", done_cnt - d0, 32'd0);
        check_eq("abort_writes", wq.size(), 32'd2);
        for (int unsigned i = 0; i < 4; i++)
            check_eq("abort_ram", 32'(ram[16 + i]), 32'(ref_mem[16 + i]));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
